uart_frame_packer: RTL and testbench
====================================

# uart_frame_packer

Snapshots the three 16-bit sensor counter results on a capture strobe and serializes them into a fixed 8-byte frame (sync, three big-endian results, checksum). It drives the byte-wide `UARTDATA`/`START` inputs of the existing `UART` transmitter. Bytes are paced by a fixed cycle gap because that transmitter exposes no busy flag. It sits directly downstream of the `counter_new` instances and directly upstream of `UART`.

## Interface
- `BYTE_GAP`, default 12000: cycles between successive `START` pulses. Must exceed one full UART character time. Legal range 2..131071, held in a 17-bit counter.
- `SYNC`, default 8'hA5: first byte of every frame.
- `CLK` in 1: single system clock. All logic is on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `capture` in 1: one-cycle strobe requesting a frame.
- `result1` in 16: sensor 1 count, sampled on an accepted capture.
- `result2` in 16: sensor 2 count.
- `result3` in 16: sensor 3 count.
- `UARTDATA` out 8: byte to transmit. Registered and stable from its `START` cycle until the next `START`.
- `START` out 1: one-cycle pulse per byte, registered.
- `busy` out 1: a frame is in progress, registered.
- `overrun` out 1: one-cycle pulse when a capture is dropped, registered.

## Operation
- Reset values: `UARTDATA`=0, `START`=0, `busy`=0, `overrun`=0. State is IDLE, byte index is 0, gap counter is 0.
- Frame layout, byte index 0..7:
  - 0: `SYNC`
  - 1, 2: result1[15:8], result1[7:0]
  - 3, 4: result2[15:8], result2[7:0]
  - 5, 6: result3[15:8], result3[7:0]
  - 7: checksum
- Checksum is the 8-bit modular sum (carry discarded) of bytes 1..6. `SYNC` is excluded. It is computed from the snapshot, not from the live inputs.
- IDLE state:
  - `capture`=1 latches result1..3 into internal snapshot registers and moves to EMIT with index 0.
  - `capture`=0 stays in IDLE.
- EMIT state (one cycle):
  - `UARTDATA` takes the byte for the current index and `START` pulses high.
  - Gap counter loads `BYTE_GAP`-1, then the state moves to WAIT.
- WAIT state:
  - The gap counter decrements each cycle.
  - When it reaches 0 with index < 7: increment index and go to EMIT.
  - When it reaches 0 with index = 7: go to IDLE.
- `busy` is high in every cycle the state is not IDLE.
- `capture` while `busy`=1 is ignored. `overrun` pulses the following cycle. The snapshot and frame in flight are unaffected.
- Input results changing mid-frame have no effect on the frame.
- `RST` mid-frame:
  - Applies on the next edge; the partial frame is abandoned, with no further `START`.
  - Outputs return to reset values.
  - A `capture` asserted in the same cycle as `RST` is ignored.

## Timing
- A capture accepted at edge t gives `START`=1 with `UARTDATA`=`SYNC` in cycle t+1.
- Byte k has its `START` in cycle t+1+k·`BYTE_GAP`, for k = 0..7.
- `busy` is high in cycles t+1 through t+8·`BYTE_GAP`. It is low at t+1+8·`BYTE_GAP`, where a new capture is accepted.
- Minimum start-to-start spacing between frames is 8·`BYTE_GAP`+1 cycles.
- `START` never asserts on two consecutive cycles, for any `BYTE_GAP` ≥ 2.
- `overrun` rises one cycle after the rejected capture.

## Structure
- Shared package holds:
  - `FRAME_LEN`=8 and the byte-index constants (`IDX_SYNC`=0, `IDX_CSUM`=7).
  - The state encoding (IDLE, EMIT, WAIT) and the `SYNC` default.
- The natural sub-module is `byte_gap_timer`: a 17-bit load/decrement counter with a `load` input, a `value` input and a `zero` output. It is reusable for other paced UART producers.
- Byte select is a mux over the snapshot. The checksum is registered at capture time from the input values.

## Test plan
- **Basic frame.** `BYTE_GAP`=16; result1=16'h1234, result2=16'h00FF, result3=16'hABCD; capture at cycle 10. Expect 8 `START` pulses at cycles 11, 27, 43, …, 123. Bytes in order: A5 12 34 00 FF AB CD BD. `busy` is high for cycles 11..138 and low at 139.
- **Mid-frame input changes and overrun.** Same setup; change all results to 16'hFFFF at cycle 30 and pulse capture at cycle 50. Frame bytes are unchanged. `overrun`=1 at cycle 51 only. No second frame follows.
- **Back-to-back frames.** All results 0; captures at cycles 10 and 139 with `BYTE_GAP`=16. Both frames are accepted: A5 00 00 00 00 00 00 00, twice. Second frame's first `START` is at cycle 140 and `overrun` never asserts.
- **Checksum wrap.** All results 16'hFFFF. Checksum = (6·FF) mod 256 = 8'hFA.
- **Reset mid-frame.** Assert `RST` for one cycle at cycle 60 during the basic frame. From cycle 61: `START`=0, `UARTDATA`=0, `busy`=0. There are no further pulses. A capture at cycle 70 starts a fresh frame with `SYNC` at cycle 71.
- **Minimum gap.** `BYTE_GAP`=2. `START` pulses are exactly 2 cycles apart, never adjacent; `busy` spans 16 cycles.

Source files
------------

// File: rtl/uart_frame_packer_pkg.sv
// rtl/uart_frame_packer_pkg.sv - shared constants, state encoding and frame helpers
//
// Purpose: frame layout constants, FSM state type, snapshot record and the
//          byte-select / checksum helpers used by uart_frame_packer.
// Ports:   none (package).
package uart_frame_packer_pkg;

    localparam int FRAME_LEN = 8;
    localparam logic [2:0] IDX_SYNC = 3'd0;
    localparam logic [2:0] IDX_CSUM = 3'd7;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int GAP_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EMIT,
        ST_WAIT
    } state_t;

    typedef struct packed {
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] r3;
    } snap_t;

    // 8-bit sum of the six result bytes; carries fall off the top.
    function automatic logic [7:0] frame_checksum(input snap_t s);
        return s.r1[15:8] + s.r1[7:0] + s.r2[15:8] + s.r2[7:0]
             + s.r3[15:8] + s.r3[7:0];
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input snap_t s,
                                              input logic [7:0] sync,
                                              input logic [7:0] csum);
        logic [7:0] b;
        case (idx)
            3'd0:    b = sync;
            3'd1:    b = s.r1[15:8];
            3'd2:    b = s.r1[7:0];
            3'd3:    b = s.r2[15:8];
            3'd4:    b = s.r2[7:0];
            3'd5:    b = s.r3[15:8];
            3'd6:    b = s.r3[7:0];
            default: b = csum;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_frame_packer_byte_gap_timer.sv
// rtl/uart_frame_packer_byte_gap_timer.sv - reloadable down-counter pacing UART bytes
//
// Purpose: load/decrement counter used to space START pulses.
// Ports:   clk, rst (sync, active-high), load, value[W-1:0] -> zero.
module byte_gap_timer
    import uart_frame_packer_pkg::*;
#(
    parameter int W = GAP_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    // Flags the cycle whose clock edge brings the count to zero, so the
    // consumer can act on that same edge instead of one cycle later.
    assign zero = (count == W'(1));

endmodule

// File: rtl/uart_frame_packer.sv
// rtl/uart_frame_packer.sv - snapshot three sensor results and pace them out as an 8-byte UART frame
//
// Purpose: on capture, snapshot result1..3 and emit SYNC, three big-endian
//          results and an 8-bit checksum, one byte per BYTE_GAP cycles.
// Ports:   CLK, RST (sync, active-high), capture, result1..3[15:0]
//          -> UARTDATA[7:0], START, busy, overrun (all registered).
module uart_frame_packer
    import uart_frame_packer_pkg::*;
#(
    parameter int unsigned BYTE_GAP = 12000,
    parameter logic [7:0]  SYNC     = SYNC_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        capture,
    input  logic [15:0] result1,
    input  logic [15:0] result2,
    input  logic [15:0] result3,
    output logic [7:0]  UARTDATA,
    output logic        START,
    output logic        busy,
    output logic        overrun
);

    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(BYTE_GAP - 1);

    state_t     state;
    logic [2:0] idx;
    logic [2:0] next_idx;
    snap_t      snap;
    snap_t      live;
    logic [7:0] csum;
    logic       gap_load;
    logic       gap_zero;

    assign live     = {result1, result2, result3};
    assign next_idx = idx + 3'd1;
    assign gap_load = (state == ST_EMIT);

    byte_gap_timer #(
        .W(GAP_W)
    ) u_gap (
        .clk  (CLK),
        .rst  (RST),
        .load (gap_load),
        .value(GAP_RELOAD),
        .zero (gap_zero)
    );

    // Outputs are registered on entry to EMIT, so START is high during the
    // EMIT cycle itself and UARTDATA holds until the next byte is chosen.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_IDLE;
            idx      <= IDX_SYNC;
            snap     <= '0;
            csum     <= 8'd0;
            UARTDATA <= 8'd0;
            START    <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            START   <= 1'b0;
            overrun <= capture && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (capture) begin
                        snap     <= live;
                        csum     <= frame_checksum(live);
                        idx      <= IDX_SYNC;
                        UARTDATA <= frame_byte(IDX_SYNC, live, SYNC, 8'd0);
                        START    <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (gap_zero) begin
                        if (idx == IDX_CSUM) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            idx      <= next_idx;
                            UARTDATA <= frame_byte(next_idx, snap, SYNC, csum);
                            START    <= 1'b1;
                            state    <= ST_EMIT;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_packer.sv
// tb/tb_uart_frame_packer.sv - self-checking bench for uart_frame_packer
module tb_uart_frame_packer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        capture;
    logic [15:0] result1, result2, result3;
    logic [7:0]  data0, data1;
    logic        start0, start1, busy0, busy1, ovr0, ovr1;

    always #5 CLK = ~CLK;

    uart_frame_packer #(.BYTE_GAP(16)) dut (
        .CLK(CLK), .RST(RST), .capture(capture),
        .result1(result1), .result2(result2), .result3(result3),
        .UARTDATA(data0), .START(start0), .busy(busy0), .overrun(ovr0)
    );

    uart_frame_packer #(.BYTE_GAP(2)) dut2 (
        .CLK(CLK), .RST(RST), .capture(capture),
        .result1(result1), .result2(result2), .result3(result3),
        .UARTDATA(data1), .START(start1), .busy(busy1), .overrun(ovr1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h required %h", name, cyc, act, exp);
        end
    endtask

    function automatic int gap_of(input int i);
        return (i == 0) ? 16 : 2;
    endfunction

    // Reference model: a frame accepted at cycle A occupies cycles A..A+8G-1,
    // byte k appears at A+k*G. Cycle n is the interval after the n-th edge.
    bit         m_active [2];
    int         m_a      [2];
    logic [7:0] m_bytes  [2][8];
    logic [7:0] e_data   [2];
    logic       e_start  [2];
    logic       e_busy   [2];
    logic       e_over   [2];

    always @(posedge CLK) begin : model
        int c;
        c = cyc + 1;
        cyc <= c;
        for (int i = 0; i < 2; i++) begin
            int g;
            int d;
            logic [7:0] s;
            g = gap_of(i);
            if (RST) begin
                m_active[i] = 1'b0;
                e_data[i]   = 8'd0;
                e_start[i]  = 1'b0;
                e_busy[i]   = 1'b0;
                e_over[i]   = 1'b0;
            end else begin
                e_over[i] = capture && e_busy[i];
                if (capture && !e_busy[i]) begin
                    m_active[i] = 1'b1;
                    m_a[i] = c;
                    m_bytes[i][0] = 8'hA5;
                    m_bytes[i][1] = result1[15:8];
                    m_bytes[i][2] = result1[7:0];
                    m_bytes[i][3] = result2[15:8];
                    m_bytes[i][4] = result2[7:0];
                    m_bytes[i][5] = result3[15:8];
                    m_bytes[i][6] = result3[7:0];
                    s = 8'd0;
                    for (int k = 1; k < 7; k++) s = s + m_bytes[i][k];
                    m_bytes[i][7] = s;
                end
                d = c - m_a[i];
                if (m_active[i] && d < 8 * g) begin
                    e_busy[i]  = 1'b1;
                    e_start[i] = ((d % g) == 0);
                    if (e_start[i]) e_data[i] = m_bytes[i][d / g];
                end else begin
                    m_active[i] = 1'b0;
                    e_busy[i]   = 1'b0;
                    e_start[i]  = 1'b0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (cyc >= 1) begin
            chk("start_g16", 32'(start0), 32'(e_start[0]));
            chk("busy_g16", 32'(busy0), 32'(e_busy[0]));
            chk("overrun_g16", 32'(ovr0), 32'(e_over[0]));
            chk("data_g16", 32'(data0), 32'(e_data[0]));
            chk("start_g2", 32'(start1), 32'(e_start[1]));
            chk("busy_g2", 32'(busy1), 32'(e_busy[1]));
            chk("overrun_g2", 32'(ovr1), 32'(e_over[1]));
            chk("data_g2", 32'(data1), 32'(e_data[1]));
        end
    end

    int         log0_c[$];
    logic [7:0] log0_d[$];
    int         log1_c[$];
    logic [7:0] log1_d[$];

    always @(negedge CLK) begin
        if (start0 === 1'b1) begin
            log0_c.push_back(cyc);
            log0_d.push_back(data0);
        end
        if (start1 === 1'b1) begin
            log1_c.push_back(cyc);
            log1_d.push_back(data1);
        end
    end

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    task automatic pulse_capture();
        capture = 1'b1;
        @(negedge CLK);
        capture = 1'b0;
    endtask

    task automatic clear_logs();
        log0_c.delete();
        log0_d.delete();
        log1_c.delete();
        log1_d.delete();
    endtask

    logic [7:0] basic_bytes [8] = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'hFF, 8'hAB, 8'hCD, 8'hBD};

    initial begin
        RST = 1'b1;
        capture = 1'b0;
        result1 = 16'h0;
        result2 = 16'h0;
        result3 = 16'h0;

        wait_to(2);
        chk("reset_start", 32'(start0), 32'h0);
        chk("reset_busy", 32'(busy0), 32'h0);
        chk("reset_data", 32'(data0), 32'h0);
        chk("reset_overrun", 32'(ovr0), 32'h0);
        RST = 1'b0;

        // Basic frame, then mid-frame input change and a dropped capture.
        result1 = 16'h1234;
        result2 = 16'h00FF;
        result3 = 16'hABCD;
        wait_to(10);
        clear_logs();
        pulse_capture();
        wait_to(26);
        chk("g2_busy_last", 32'(busy1), 32'h1);
        wait_to(27);
        chk("g2_busy_end", 32'(busy1), 32'h0);
        if (log1_c.size() != 8) chk("g2_count", 32'(log1_c.size()), 32'd8);
        else for (int k = 0; k < 8; k++) begin
            chk("g2_start_cycle", 32'(log1_c[k]), 32'(11 + 2 * k));
            chk("g2_byte", 32'(log1_d[k]), 32'(basic_bytes[k]));
        end
        wait_to(30);
        result1 = 16'hFFFF;
        result2 = 16'hFFFF;
        result3 = 16'hFFFF;
        wait_to(50);
        pulse_capture();
        chk("overrun_51", 32'(ovr0), 32'h1);
        @(negedge CLK);
        chk("overrun_52", 32'(ovr0), 32'h0);
        wait_to(138);
        chk("busy_138", 32'(busy0), 32'h1);
        wait_to(139);
        chk("busy_139", 32'(busy0), 32'h0);
        wait_to(200);
        if (log0_c.size() != 8) chk("basic_count", 32'(log0_c.size()), 32'd8);
        else for (int k = 0; k < 8; k++) begin
            chk("basic_start_cycle", 32'(log0_c[k]), 32'(11 + 16 * k));
            chk("basic_byte", 32'(log0_d[k]), 32'(basic_bytes[k]));
        end

        // Back-to-back frames at the minimum spacing.
        result1 = 16'h0;
        result2 = 16'h0;
        result3 = 16'h0;
        clear_logs();
        wait_to(210);
        pulse_capture();
        wait_to(339);
        pulse_capture();
        wait_to(500);
        if (log0_c.size() != 16) chk("b2b_count", 32'(log0_c.size()), 32'd16);
        else begin
            chk("b2b_first", 32'(log0_c[0]), 32'd211);
            chk("b2b_second", 32'(log0_c[8]), 32'd340);
            for (int k = 0; k < 16; k++)
                chk("b2b_byte", 32'(log0_d[k]), (k % 8 == 0) ? 32'hA5 : 32'h0);
        end

        // Checksum wrap.
        result1 = 16'hFFFF;
        result2 = 16'hFFFF;
        result3 = 16'hFFFF;
        clear_logs();
        wait_to(510);
        pulse_capture();
        wait_to(700);
        if (log0_c.size() != 8) chk("wrap_count", 32'(log0_c.size()), 32'd8);
        else begin
            chk("wrap_byte1", 32'(log0_d[1]), 32'hFF);
            chk("wrap_csum", 32'(log0_d[7]), 32'hFA);
        end

        // Reset mid-frame, then a fresh frame.
        result1 = 16'h1234;
        result2 = 16'h00FF;
        result3 = 16'hABCD;
        clear_logs();
        wait_to(710);
        pulse_capture();
        wait_to(760);
        RST = 1'b1;
        capture = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        capture = 1'b0;
        chk("rst_mid_start", 32'(start0), 32'h0);
        chk("rst_mid_data", 32'(data0), 32'h0);
        chk("rst_mid_busy", 32'(busy0), 32'h0);
        wait_to(770);
        pulse_capture();
        chk("fresh_start", 32'(start0), 32'h1);
        chk("fresh_sync", 32'(data0), 32'hA5);
        wait_to(772);
        chk("rst_mid_pulses", 32'(log0_c.size()), 32'd5);
        if (log0_c.size() == 5) chk("fresh_cycle", 32'(log0_c[4]), 32'd771);

        // Randomized traffic against the model.
        wait_to(1000);
        for (int n = 0; n < 4000; n++) begin
            capture = ($urandom_range(0, 59) == 0);
            RST = ($urandom_range(0, 699) == 0);
            if ($urandom_range(0, 3) == 0) begin
                result1 = 16'($urandom);
                result2 = 16'($urandom);
                result3 = 16'($urandom);
            end
            @(negedge CLK);
        end
        capture = 1'b0;
        RST = 1'b0;
        repeat (200) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
